// File: rtl/fast_corner_collector.sv
// fast_corner_collector: FIFO-buffered corner coordinate sink with per-frame statistics; CORNER_BORDER_FILTER_EN discards border corners
module fast_corner_collector #(
  parameter int COORD_WIDTH = 10,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_CORNERS = 1000,
  parameter int CNT_WIDTH   = 11,
  parameter int COL_NUM     = 30,
  parameter int ROW_NUM     = 20,
  parameter int BORDER      = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            sof,
  input  logic                            iscorner,
  input  logic [COORD_WIDTH-1:0]          x_coord,
  input  logic [COORD_WIDTH-1:0]          y_coord,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [2*COORD_WIDTH-1:0]        m_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]            frame_cnt,
  output logic [CNT_WIDTH-1:0]            frame_drop,
  output logic                            frame_cnt_valid,
  output logic                            overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;
  localparam logic [AW:0] L_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] L_MAX = CNT_WIDTH'(MAX_CORNERS);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_CORNERS >= 2**CNT_WIDTH ||
      2*BORDER > COL_NUM || 2*BORDER > ROW_NUM) begin : g_bad_cfg
    $error("fast_corner_collector: invalid parameter set");
  end
  logic [0:0] r_state;
  logic [2*COORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_level;
  logic [CNT_WIDTH-1:0] r_live_cnt, r_live_drop, r_frame_cnt, r_frame_drop;
  logic r_fcv, r_overflow;
  logic w_pass, w_pop, w_full, w_cand, w_under, w_accept, w_drop, w_close;
  logic [CNT_WIDTH-1:0] w_base_cnt, w_base_drop;
`ifdef CORNER_BORDER_FILTER_EN
  localparam logic [COORD_WIDTH-1:0] L_LO = COORD_WIDTH'(BORDER);
  localparam logic [COORD_WIDTH-1:0] L_XHI = COORD_WIDTH'(COL_NUM - BORDER);
  localparam logic [COORD_WIDTH-1:0] L_YHI = COORD_WIDTH'(ROW_NUM - BORDER);
  assign w_pass = x_coord >= L_LO && x_coord < L_XHI && y_coord >= L_LO && y_coord < L_YHI;
`else
  assign w_pass = 1'b1;
`endif
  assign m_valid = r_level != '0;
  assign m_data = r_mem[r_rd];
  assign fifo_level = r_level;
  assign frame_cnt = r_frame_cnt;
  assign frame_drop = r_frame_drop;
  assign frame_cnt_valid = r_fcv;
  assign overflow = r_overflow;
  assign w_pop = m_valid && m_ready;
  assign w_full = r_level == L_DEPTH;
  assign w_close = sof && r_state == S_COLLECT;
  // A corner arriving with sof is charged to the frame that sof opens
  assign w_base_cnt = sof ? '0 : r_live_cnt;
  assign w_base_drop = sof ? '0 : r_live_drop;
  assign w_cand = ce && iscorner && w_pass && (r_state == S_COLLECT || sof);
  assign w_under = w_base_cnt < L_MAX;
  assign w_accept = w_cand && w_under && (!w_full || w_pop);
  assign w_drop = w_cand && !w_accept;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
      r_live_cnt <= '0;
      r_live_drop <= '0;
      r_frame_cnt <= '0;
      r_frame_drop <= '0;
      r_fcv <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (sof) r_state <= S_COLLECT;
      r_fcv <= w_close;
      if (w_close) begin
        r_frame_cnt <= r_live_cnt;
        r_frame_drop <= r_live_drop;
      end
      r_live_cnt <= w_base_cnt + CNT_WIDTH'(w_accept);
      r_live_drop <= w_base_drop + CNT_WIDTH'(w_drop && w_base_drop != '1);
      if (w_drop && w_under) r_overflow <= 1'b1;
      if (w_accept) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + (AW+1)'(w_accept) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr] <= {y_coord, x_coord};
  end
endmodule
